polynomial_matrix_multiplication: RTL and testbench
===================================================

POLYNOMIAL_MATRIX_MULTIPLICATION -- requirements
Module: polynomial_matrix_multiplication

Interface
REQ-001 The block SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 enable  input  1  when high, the output register loads a new product on the next rising edge.
REQ-005 polynomial1  input  4 x 32 signed  operand a; index i is the coefficient of x^i.
REQ-006 polynomial2  input  4 x 32 signed  operand b; same coefficient ordering.
REQ-007 polynomial_out  output  4 x 32  registered product c, each coefficient in 0..16.
REQ-008 Companion leaf random_number_generator parameters:
- MIN_VALUE, default -17, signed lower bound.
- MAX_VALUE, default 17, signed upper bound.
- SEED, default 32'hACE1_2468, LFSR start state.
REQ-009 random_number_generator ports:
- clk, rst_n: as above.
- enable  input  1  advance the generator.
- random_number  output  32 signed  registered sample.

Function
REQ-010 The multiplier SHALL compute c = a*b in Z_17[x]/(x^4+1), i.e. negacyclic convolution: c_k = sum over i+j=k of a_i*b_j, minus sum over i+j=k+4 of a_i*b_j.
REQ-011 Each input coefficient SHALL first be reduced to 0..16 with mathematical (non-negative) mod 17, so any signed 32-bit value is legal; e.g. -1 maps to 16 and -17 maps to 0.
REQ-012 The subtraction in REQ-010 SHALL be realized as the addition of 17 minus the reduced product term; intermediate sums SHALL use at least 12 bits, and overflow SHALL be impossible.
REQ-013 The final coefficient SHALL be reduced to 0..16 and zero-extended to 32 bits.
REQ-014 Latency SHALL be 1 cycle: operands sampled at edge N with enable=1 appear on polynomial_out after edge N.
REQ-015 With enable=0, polynomial_out SHALL hold its value, and input changes SHALL have no effect.
REQ-016 random_number_generator SHALL keep a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shifted once per clock while enable=1 and held otherwise.
REQ-017 On each enabled edge, random_number SHALL load MIN_VALUE + (next_lfsr mod (MAX_VALUE-MIN_VALUE+1)), always within MIN_VALUE..MAX_VALUE inclusive.
REQ-018 If SEED is 0, the LFSR SHALL start at 1, so the all-zero lock-up state never occurs.
REQ-019 If MIN_VALUE equals MAX_VALUE, random_number SHALL remain MIN_VALUE.
REQ-020 MIN_VALUE > MAX_VALUE SHALL be rejected at elaboration.

Reset
REQ-021 rst_n low SHALL asynchronously clear all four polynomial_out coefficients to 0.
REQ-022 rst_n low SHALL asynchronously set the RNG LFSR to SEED and random_number to MIN_VALUE.
REQ-023 After rst_n deasserts, the first enabled edge SHALL behave as in REQ-014 and REQ-017.
REQ-024 Reset asserted mid-operation SHALL discard the in-flight result.

Structure
REQ-025 A shared package SHALL hold N=4, Q=17, COEF_W=32, the coefficient-array typedef, and a mod-Q function.
REQ-026 The multiplier SHALL be one module with combinational convolution and a single output register stage.
REQ-027 A mod_q_reduce function (or tiny sub-module) SHALL be reused for input and output reduction.
REQ-028 random_number_generator SHALL be a separate leaf module in the same package scope.

Verification
REQ-029 Identity: a=[1,0,0,0], b=[3,4,5,6], enable=1 -> polynomial_out=[3,4,5,6] one cycle later.
REQ-030 Wrap: a=[0,1,0,0], b=[0,0,0,1] -> [16,0,0,0] (x^4 = -1).
REQ-031 Signed input: a=[-1,0,0,0], b=[1,2,3,4] -> [16,15,14,13].
REQ-032 Full case: a=[11,16,16,6], b=[0,1,-1,-1] -> [9,16,11,6]; then set enable=0, change inputs, and confirm the output holds; assert rst_n mid-run and confirm the output becomes [0,0,0,0] immediately.
REQ-033 RNG range: MIN=-1, MAX=17, 10000 enabled cycles -> every sample in -1..17 and all 19 values observed; enable=0 holds the value; two instances with different SEED produce different sequences.

Source files
------------

// File: rtl/polynomial_matrix_multiplication_pkg.sv
// Shared constants, types and the mod-17 reduction helper for the
// polynomial multiplier over Z_17[x]/(x^4+1) and its companion RNG.
package polynomial_matrix_multiplication_pkg;

  // Ring parameters: degree-4 negacyclic ring over Z_17.
  localparam int N      = 4;
  localparam int Q      = 17;
  localparam int COEF_W = 32;

  // A reduced coefficient (0..16) needs 5 bits.
  localparam int RED_W  = 5;

  // Accumulator width. The worst case is four terms of at most 17 each (68),
  // so 12 bits leave ample headroom and can never overflow.
  localparam int SUM_W  = 12;

  // Galois LFSR feedback mask for x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t                    coef_array_t [N];
  typedef logic [RED_W-1:0]         red_t;

  // Mathematical (non-negative) modulo 17 of any signed 32-bit value.
  // The SV '%' operator truncates toward zero, so a negative remainder is
  // lifted back into 0..16 by adding Q once.
  function automatic red_t mod_q_reduce(input coef_t value);
    coef_t rem;
    rem = value % coef_t'(Q);
    if (rem < 32'sd0) begin
      rem = rem + coef_t'(Q);
    end else begin
      rem = rem;
    end
    return rem[RED_W-1:0];
  endfunction

endpackage

// File: rtl/polynomial_matrix_multiplication_rng.sv
// Bounded pseudo-random sample generator built on a 32-bit Galois LFSR.
// Each enabled clock advances the LFSR once and registers a sample in
// MIN_VALUE..MAX_VALUE inclusive.
module random_number_generator
  import polynomial_matrix_multiplication_pkg::*;
#(
  parameter int          MIN_VALUE = -17,
  parameter int          MAX_VALUE = 17,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic signed [COEF_W-1:0] random_number
);

  // A zero seed would lock the LFSR at zero forever, so start at 1 instead.
  localparam logic [31:0] START_STATE = (SEED == 32'd0) ? 32'd1 : SEED;

  // Range size computed in 64 bits so extreme bounds cannot wrap.
  localparam longint      RANGE   = longint'(MAX_VALUE) - longint'(MIN_VALUE) + 64'sd1;
  localparam logic [63:0] RANGE_W = 64'(RANGE);
  localparam logic [31:0] MIN_W   = MIN_VALUE;

  // An inverted range has no legal samples; refuse to build it.
  generate
    if (MIN_VALUE > MAX_VALUE) begin : g_bad_range
      $error("random_number_generator: MIN_VALUE must not exceed MAX_VALUE");
    end
  endgenerate

  logic [31:0] lfsr_r;
  logic [31:0] lfsr_next_s;
  logic [31:0] offset_s;
  logic [31:0] sample_s;

  // Next LFSR state and the sample derived from it.
  always_comb begin
    lfsr_next_s = {1'b0, lfsr_r[31:1]} ^ (lfsr_r[0] ? LFSR_MASK : 32'd0);
    offset_s    = 32'({32'd0, lfsr_next_s} % RANGE_W);
    sample_s    = MIN_W + offset_s;
  end

  // LFSR and sample registers: advance only while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r        <= START_STATE;
      random_number <= MIN_W;
    end else if (enable) begin
      lfsr_r        <= lfsr_next_s;
      random_number <= sample_s;
    end else begin
      lfsr_r        <= lfsr_r;
      random_number <= random_number;
    end
  end

endmodule

// File: rtl/polynomial_matrix_multiplication.sv
// Multiplier in Z_17[x]/(x^4+1): a combinational negacyclic convolution of
// the reduced operands followed by one output register stage.
module polynomial_matrix_multiplication
  import polynomial_matrix_multiplication_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [COEF_W-1:0] polynomial1    [N],
  input  logic signed [COEF_W-1:0] polynomial2    [N],
  output logic        [COEF_W-1:0] polynomial_out [N]
);

  red_t              red_a_s  [N];
  red_t              red_b_s  [N];
  logic [SUM_W-1:0]  sum_s    [N];
  logic [COEF_W-1:0] next_s   [N];

  // Bring every input coefficient into 0..16 before multiplying.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      red_a_s[i] = mod_q_reduce(polynomial1[i]);
      red_b_s[i] = mod_q_reduce(polynomial2[i]);
    end
  end

  // Negacyclic convolution: terms with i+j=k add, terms that wrap past x^3
  // pick up x^4 = -1 and are added as (17 - term) to stay non-negative.
  always_comb begin
    logic [2*RED_W-1:0] prod_v;
    red_t               term_v;
    prod_v = '0;
    term_v = '0;
    for (int k = 0; k < N; k++) begin
      sum_s[k] = '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          prod_v = (2*RED_W)'(red_a_s[i]) * (2*RED_W)'(red_b_s[j]);
          term_v = mod_q_reduce(coef_t'({{(COEF_W-2*RED_W){1'b0}}, prod_v}));
          if ((i + j) == k) begin
            sum_s[k] = sum_s[k] + SUM_W'(term_v);
          end else if ((i + j) == (k + N)) begin
            sum_s[k] = sum_s[k] + (SUM_W'(Q) - SUM_W'(term_v));
          end else begin
            sum_s[k] = sum_s[k];
          end
        end
      end
    end
  end

  // Final reduction of each accumulated coefficient, zero-extended.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      next_s[k] = {{(COEF_W-RED_W){1'b0}},
                   mod_q_reduce(coef_t'({{(COEF_W-SUM_W){1'b0}}, sum_s[k]}))};
    end
  end

  // Output register: load the product when enabled, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        polynomial_out[k] <= '0;
      end
    end else if (enable) begin
      for (int k = 0; k < N; k++) begin
        polynomial_out[k] <= next_s[k];
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        polynomial_out[k] <= polynomial_out[k];
      end
    end
  end

endmodule

// File: tb/tb_polynomial_matrix_multiplication.sv
// Directed self-checking bench for polynomial_matrix_multiplication and the
// random_number_generator leaf.
module tb_polynomial_matrix_multiplication;
  import polynomial_matrix_multiplication_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic rng_en;
  logic signed [31:0] p1   [4];
  logic signed [31:0] p2   [4];
  logic        [31:0] pout [4];
  logic signed [31:0] rn_a;
  logic signed [31:0] rn_b;
  logic signed [31:0] rn_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  polynomial_matrix_multiplication dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .polynomial1(p1), .polynomial2(p2), .polynomial_out(pout)
  );

  random_number_generator #(.MIN_VALUE(-1), .MAX_VALUE(17), .SEED(32'hACE1_2468)) rng_a (
    .clk(clk), .rst_n(rst_n), .enable(rng_en), .random_number(rn_a)
  );

  random_number_generator #(.MIN_VALUE(-1), .MAX_VALUE(17), .SEED(32'h1234_5678)) rng_b (
    .clk(clk), .rst_n(rst_n), .enable(rng_en), .random_number(rn_b)
  );

  random_number_generator #(.MIN_VALUE(5), .MAX_VALUE(5), .SEED(32'h0000_0000)) rng_z (
    .clk(clk), .rst_n(rst_n), .enable(rng_en), .random_number(rn_z)
  );

  task automatic drive(input logic signed [31:0] a [4], input logic signed [31:0] b [4]);
    for (int i = 0; i < 4; i++) begin
      p1[i] = a[i];
      p2[i] = b[i];
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp [4];
    exp = '{32'd0, 32'd0, 32'd0, 32'd0};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL reset c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    checks++;
    if (rn_a !== -32'sd1) begin
      errors++;
      $display("FAIL reset_rng: got %0d expected -1", rn_a);
    end
    checks++;
    if (rn_z !== 32'sd5) begin
      errors++;
      $display("FAIL reset_rng_z: got %0d expected 5", rn_z);
    end
  endtask

  task automatic test_identity_wrap_signed();
    logic [31:0] exp [4];
    // Identity
    drive('{32'sd1, 32'sd0, 32'sd0, 32'sd0}, '{32'sd3, 32'sd4, 32'sd5, 32'sd6});
    enable = 1'b1;
    @(posedge clk); #1;
    exp = '{32'd3, 32'd4, 32'd5, 32'd6};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL identity c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    // x * x^3 = x^4 = -1
    drive('{32'sd0, 32'sd1, 32'sd0, 32'sd0}, '{32'sd0, 32'sd0, 32'sd0, 32'sd1});
    @(posedge clk); #1;
    exp = '{32'd16, 32'd0, 32'd0, 32'd0};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL wrap c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    // Negative operand coefficient
    drive('{-32'sd1, 32'sd0, 32'sd0, 32'sd0}, '{32'sd1, 32'sd2, 32'sd3, 32'sd4});
    @(posedge clk); #1;
    exp = '{32'd16, 32'd15, 32'd14, 32'd13};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL signed c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    // (2+3x)(4+5x) = 8 + 22x + 15x^2 -> 8, 5, 15, 0
    drive('{32'sd2, 32'sd3, 32'sd0, 32'sd0}, '{32'sd4, 32'sd5, 32'sd0, 32'sd0});
    enable = 1'b1;
    @(posedge clk); #1;
    exp = '{32'd8, 32'd5, 32'd15, 32'd0};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL b2b_small c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    // Extreme inputs: 2^31-1 = 8 mod 17, -2^31 = 8 mod 17, -17 = 0, 34 = 0
    drive('{32'sh7FFF_FFFF, -32'sd17, 32'sd34, 32'sd0}, '{32'sd1, 32'sd0, 32'sd0, 32'sh8000_0000});
    @(posedge clk); #1;
    // a = 8, b = 1 + 8x^3 -> c = 8 + 64x^3 -> 8, 0, 0, 13
    exp = '{32'd8, 32'd0, 32'd0, 32'd13};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL b2b_extreme c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
  endtask

  task automatic test_full_hold_reset();
    logic [31:0] exp [4];
    drive('{32'sd11, 32'sd16, 32'sd16, 32'sd6}, '{32'sd0, 32'sd1, -32'sd1, -32'sd1});
    enable = 1'b1;
    @(posedge clk); #1;
    exp = '{32'd9, 32'd16, 32'd11, 32'd6};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL full c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    // Hold with enable low while inputs change
    enable = 1'b0;
    drive('{32'sd1, 32'sd0, 32'sd0, 32'sd0}, '{32'sd3, 32'sd4, 32'sd5, 32'sd6});
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL hold c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    // Load identity result, then reset between edges
    enable = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp = '{32'd0, 32'd0, 32'd0, 32'd0};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL midreset c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL inreset c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    // First enabled edge after release
    @(negedge clk);
    rst_n = 1'b1;
    drive('{32'sd0, 32'sd1, 32'sd0, 32'sd0}, '{32'sd0, 32'sd0, 32'sd0, 32'sd1});
    @(posedge clk); #1;
    exp = '{32'd16, 32'd0, 32'd0, 32'd0};
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pout[k] !== exp[k]) begin
        errors++;
        $display("FAIL post_reset c%0d: got %0d expected %0d", k, pout[k], exp[k]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_rng();
    logic [31:0] m;
    int          expv;
    int          mism;
    int          bad;
    int          zbad;
    int          same;
    logic [18:0] seen;
    m    = 32'hACE1_2468;
    expv = -1;
    mism = 0;
    bad  = 0;
    zbad = 0;
    same = 0;
    seen = '0;
    @(negedge clk);
    rng_en = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      m    = {1'b0, m[31:1]} ^ (m[0] ? 32'h8020_0003 : 32'd0);
      expv = -1 + int'(m % 32'd19);
      if (rn_a !== expv) mism++;
      if (rn_a < -1 || rn_a > 17 || rn_b < -1 || rn_b > 17) bad++;
      else seen[rn_a + 1] = 1'b1;
      if (rn_a == rn_b) same++;
      if (rn_z !== 32'sd5) zbad++;
    end
    rng_en = 1'b0;
    checks++;
    if (mism !== 0) begin
      errors++;
      $display("FAIL rng_sequence: got %0d mismatching samples expected 0", mism);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rng_range: got %0d out-of-range samples expected 0", bad);
    end
    checks++;
    if (seen !== 19'h7FFFF) begin
      errors++;
      $display("FAIL rng_coverage: got seen=%h expected 7ffff", seen);
    end
    checks++;
    if (same >= 10000) begin
      errors++;
      $display("FAIL rng_seeds: got %0d equal samples expected fewer than 10000", same);
    end
    checks++;
    if (zbad !== 0) begin
      errors++;
      $display("FAIL rng_fixed: got %0d samples not 5 expected 0", zbad);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rn_a !== expv) begin
      errors++;
      $display("FAIL rng_hold: got %0d expected %0d", rn_a, expv);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    rng_en = 1'b0;
    drive('{32'sd0, 32'sd0, 32'sd0, 32'sd0}, '{32'sd0, 32'sd0, 32'sd0, 32'sd0});
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_identity_wrap_signed();
    test_back_to_back();
    test_full_hold_reset();
    test_rng();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
